// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-stream loaded instruction memory with a registered, latency-1 fetch port.
// A load session restarts writing at word 0; a partial final word is zero-padded on exit.
module instr_fetch_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic                     load_valid,
    input  logic [7:0]               load_byte,
    output logic                     load_ovf,
    output logic [$clog2(DEPTH):0]   load_words,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [31:0]              resp_instr,
    output logic                     resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t      state_q, state_d;
    logic [AW:0] words_q, words_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] buf_q, buf_d;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mem [DEPTH];
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_instr_q;
    logic        acc, err;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        we      = 1'b0;
        wdata   = buf_q;
        case (state_q)
            IDLE, READY: if (load_en) begin
                state_d = LOAD;
                words_d = '0;
                ovf_d   = 1'b0;
                lane_d  = '0;
                buf_d   = '0;
            end
            LOAD: if (!load_en) begin
                // Unfilled upper lanes are already zero because buf is cleared per word.
                state_d = READY;
                we      = lane_q != 2'd0;
                words_d = words_q + {{AW{1'b0}}, lane_q != 2'd0};
                lane_d  = '0;
                buf_d   = '0;
            end else if (load_valid) begin
                if (words_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    buf_d[{lane_q, 3'b000} +: 8] = load_byte;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we      = 1'b1;
                        wdata   = buf_d;
                        words_d = words_q + ONE;
                        buf_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            words_q <= '0;
            ovf_q   <= 1'b0;
            lane_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[words_q[AW-1:0]] <= wdata;
    end

    // load_words never exceeds DEPTH, so this bound also rejects indices past the array.
    assign req_ready = (state_q == READY) && !load_en;
    assign acc       = req_valid && req_ready;
    assign err       = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[ADDR_W-1:2]} >= {{(ADDR_W-AW-1){1'b0}}, words_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_instr_q <= '0;
        end else begin
            resp_valid_q <= acc;
            resp_err_q   <= acc && err;
            resp_instr_q <= (acc && !err) ? mem[req_addr[AW+1:2]] : 32'h0;
        end
    end

    assign load_ovf   = ovf_q;
    assign load_words = words_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_instr = resp_instr_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed table-driven bench; a DEPTH=256 and a DEPTH=4 instance share all inputs.
module tb_instr_fetch_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0, load_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;

    logic        ovf, rdy, v, e;
    logic [8:0]  words;
    logic [31:0] ins;
    logic        ovf4, rdy4, v4, e4;
    logic [2:0]  words4;
    logic [31:0] ins4;

    int checks = 0, errors = 0;
    logic [7:0] prog [32];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    vec_t tbl [8];

    instr_fetch_mem dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid),
        .load_byte(load_byte), .load_ovf(ovf), .load_words(words),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy),
        .resp_valid(v), .resp_instr(ins), .resp_err(e)
    );

    instr_fetch_mem #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid),
        .load_byte(load_byte), .load_ovf(ovf4), .load_words(words4),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy4),
        .resp_valid(v4), .resp_instr(ins4), .resp_err(e4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic load_prog(input int n);
        load_en = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_byte  = prog[i];
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee, input bit four);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk("req_ready", four ? rdy4 : rdy, 1);
        tick();
        req_valid = 1'b0;
        chk("resp_valid", four ? v4 : v, 1);
        chk("resp_instr", four ? ins4 : ins, ei);
        chk("resp_err", four ? e4 : e, ee);
    endtask

    initial begin
        tbl[0] = '{32'h0,   32'h00000013, 1'b0};
        tbl[1] = '{32'h4,   32'h00100093, 1'b0};
        tbl[2] = '{32'h2,   32'h0,        1'b1};
        tbl[3] = '{32'h8,   32'h0,        1'b1};
        tbl[4] = '{32'h400, 32'h0,        1'b1};
        tbl[5] = '{32'h0,   32'h04030201, 1'b0};
        tbl[6] = '{32'h4,   32'h00000605, 1'b0};
        tbl[7] = '{32'h8,   32'h0,        1'b1};

        tick();
        tick();
        chk("rst resp_valid", v, 0);
        chk("rst resp_err", e, 0);
        chk("rst resp_instr", ins, 0);
        chk("rst req_ready", rdy, 0);
        chk("rst load_words", words, 0);
        chk("rst load_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
        load_prog(8);
        chk("load1 words", words, 2);
        chk("load1 ovf", ovf, 0);
        for (int i = 0; i < 5; i++) fetch(tbl[i].addr, tbl[i].instr, tbl[i].err, 1'b0);
        tick();
        chk("idle resp_valid", v, 0);

        for (int i = 0; i < 6; i++) prog[i] = 8'(i + 1);
        load_prog(6);
        chk("load2 words", words, 2);
        for (int i = 5; i < 8; i++) fetch(tbl[i].addr, tbl[i].instr, tbl[i].err, 1'b0);

        for (int i = 0; i < 20; i++) prog[i] = 8'(i);
        load_prog(20);
        chk("d4 words", words4, 4);
        chk("d4 ovf", ovf4, 1);
        chk("d256 words", words, 5);
        chk("d256 ovf", ovf, 0);
        fetch(32'h0, 32'h03020100, 1'b0, 1'b1);
        fetch(32'hC, 32'h0f0e0d0c, 1'b0, 1'b1);
        fetch(32'h10, 32'h0, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) prog[i] = 8'hA0 + 8'(i);
        load_prog(4);
        chk("reload ovf", ovf4, 0);
        chk("reload words", words4, 1);
        fetch(32'h0, 32'hA3A2A1A0, 1'b0, 1'b1);
        fetch(32'h4, 32'h0, 1'b1, 1'b1);

        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        chk("b2b0 valid", v, 1);
        chk("b2b0 instr", ins, 32'hA3A2A1A0);
        tick();
        req_addr = 32'h0;
        chk("b2b1 valid", v, 1);
        chk("b2b1 err", e, 1);
        tick();
        req_valid = 1'b0;
        chk("b2b2 valid", v, 1);
        chk("b2b2 instr", ins, 32'hA3A2A1A0);
        chk("b2b2 err", e, 0);
        tick();
        chk("b2b end valid", v, 0);

        req_valid = 1'b1; load_en = 1'b1;
        #1;
        chk("load+req ready", rdy, 0);
        tick();
        req_valid = 1'b0;
        chk("load+req resp", v, 0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'h55;
            tick();
        end
        load_valid = 1'b0; load_en = 1'b0; rst_n = 1'b0;
        tick();
        chk("abort words", words, 0);
        chk("abort ovf", ovf, 0);
        chk("abort ready", rdy, 0);
        rst_n = 1'b1;
        tick();
        chk("idle ready", rdy, 0);
        load_prog(0);
        chk("empty words", words, 0);
        fetch(32'h0, 32'h0, 1'b1, 1'b0);

        req_valid = 1'b1; req_addr = 32'h0; rst_n = 1'b0;
        #1;
        chk("pre-rst ready", rdy, 1);
        tick();
        req_valid = 1'b0;
        chk("rst drop valid", v, 0);
        chk("rst drop err", e, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
